// File: rtl/tank_status_pkg.sv
// Shared types, packed-word field offsets and popcount helper for the tank status tracker.
package tank_status_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_DEAD  = 2'd1,
        ST_OUT   = 2'd2
    } tank_state_e;

    localparam int POS_ALIVE_BIT   = 0;
    localparam int POS_X_LSB       = 1;
    localparam int POS_Y_LSB       = 11;
    localparam int ATTR_HEALTH_LSB = 0;
    localparam int ATTR_LIVES_LSB  = 8;
    localparam int ATTR_STATE_LSB  = 14;
    localparam int POP_W           = 64;

    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) n = n + 7'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/tank_status_tracker_if.sv
// Frame-rate bus between the game logic and the tank status tracker.
// The score_reg word exists only when TANK_SCORE_EN is defined.
interface tank_status_tracker_if #(
    parameter int N_TANK   = 2,
    parameter int N_BULLET = 8
);
    logic [N_TANK-1:0][N_BULLET-1:0]        bullet_active;
    logic [N_TANK-1:0][9:0]                 tank_x;
    logic [N_TANK-1:0][9:0]                 tank_y;
    logic [N_TANK*N_BULLET-1:0][N_TANK-1:0] hit;
    logic [N_TANK-1:0]                      to_cure;
    logic                                   cured;
    logic [N_TANK-1:0][31:0]                bullet_num_reg;
    logic [N_TANK-1:0][31:0]                tank_pos_reg;
    logic [N_TANK-1:0][31:0]                health_attr_reg_out;
    logic [N_TANK-1:0]                      tank_alive;
    logic                                   game_over;
`ifdef TANK_SCORE_EN
    logic [N_TANK-1:0][31:0]                score_reg;
`endif

    modport master (
        output bullet_active, tank_x, tank_y, hit, to_cure,
`ifdef TANK_SCORE_EN
        input  score_reg,
`endif
        input  cured, bullet_num_reg, tank_pos_reg, health_attr_reg_out, tank_alive, game_over
    );

    modport slave (
        input  bullet_active, tank_x, tank_y, hit, to_cure,
`ifdef TANK_SCORE_EN
        output score_reg,
`endif
        output cured, bullet_num_reg, tank_pos_reg, health_attr_reg_out, tank_alive, game_over
    );
endinterface

// File: rtl/tank_life_fsm.sv
// Per-tank health/lives/invulnerability/respawn state machine.
// state    | meaning
// ST_ALIVE | in play; takes hits unless invulnerable, accepts cures
// ST_DEAD  | waiting out the respawn timer; hits and cures ignored
// ST_OUT   | no lives left; terminal until Reset
module tank_life_fsm
    import tank_status_pkg::*;
#(
    parameter int HW             = 5,
    parameter int INIT_HEALTH    = 5,
    parameter int MAX_HEALTH     = 8,
    parameter int INVULN_FRAMES  = 30,
    parameter int RESPAWN_FRAMES = 120,
    parameter int LIVES          = 3
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic [HW-1:0] hits,
    input  logic          cure_req,
    output logic [7:0]    health,
    output logic [3:0]    lives,
    output tank_state_e   state,
    output logic          alive_nxt,
`ifdef TANK_SCORE_EN
    output logic          hit_applied,
    output logic          kill,
`endif
    output logic          cure_ok
);
    localparam int IW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam int RW = $clog2(RESPAWN_FRAMES + 1);

    tank_state_e   state_q, state_d;
    logic [7:0]    health_q, health_d, hit_left;
    logic [3:0]    lives_q, lives_d;
    logic [IW-1:0] inv_q, inv_d;
    logic [RW-1:0] resp_q, resp_d;
    logic          dies;

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        lives_d  = lives_q;
        inv_d    = inv_q;
        resp_d   = resp_q;
        hit_left = health_q;
        dies     = 1'b0;
        cure_ok  = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (inv_q != '0) begin
                    inv_d = inv_q - IW'(1);
                end else if (hits != '0) begin
                    if (16'(hits) >= 16'(health_q)) begin
                        dies     = 1'b1;
                        health_d = '0;
                        lives_d  = lives_q - 4'd1;
                        if (lives_q == 4'd1) begin
                            state_d = ST_OUT;
                        end else begin
                            state_d = ST_DEAD;
                            resp_d  = RW'(RESPAWN_FRAMES);
                        end
                    end else begin
                        hit_left = health_q - 8'(hits);
                        inv_d    = IW'(INVULN_FRAMES);
                    end
                end
                // a killing blow swallows any cure requested in the same frame
                if (!dies) begin
                    cure_ok  = cure_req && (hit_left < 8'(MAX_HEALTH));
                    health_d = hit_left + {7'b0, cure_ok};
                end
            end
            ST_DEAD: begin
                if (resp_q == RW'(1)) begin
                    state_d  = ST_ALIVE;
                    health_d = 8'(INIT_HEALTH);
                    inv_d    = IW'(INVULN_FRAMES);
                    resp_d   = '0;
                end else begin
                    resp_d = resp_q - RW'(1);
                end
            end
            ST_OUT:  health_d = '0;
            default: state_d = ST_ALIVE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= ST_ALIVE;
            health_q <= 8'(INIT_HEALTH);
            lives_q  <= 4'(LIVES);
            inv_q    <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            lives_q  <= lives_d;
            inv_q    <= inv_d;
            resp_q   <= resp_d;
        end
    end

    assign health    = health_q;
    assign lives     = lives_q;
    assign state     = state_q;
    assign alive_nxt = (state_d == ST_ALIVE);
`ifdef TANK_SCORE_EN
    assign hit_applied = (state_q == ST_ALIVE) && (inv_q == '0) && (hits != '0);
    assign kill        = dies;
`endif
endmodule

// File: rtl/tank_status_tracker.sv
// Per-frame status tracker for N_TANK tanks: bullet counts, packed positions, life FSMs,
// cured pulse and game_over. Define TANK_SCORE_EN to add per-tank score words.
module tank_status_tracker
    import tank_status_pkg::*;
#(
    parameter int N_TANK         = 2,
    parameter int N_BULLET       = 8,
    parameter int INIT_HEALTH    = 5,
    parameter int MAX_HEALTH     = 8,
    parameter int INVULN_FRAMES  = 30,
    parameter int RESPAWN_FRAMES = 120,
    parameter int LIVES          = 3
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    tank_status_tracker_if.slave bus
);
    localparam int HW = $clog2(N_TANK * N_BULLET + 1);

    logic [N_TANK-1:0][HW-1:0] hits;
    logic [N_TANK-1:0][31:0]   bnum_q, bnum_d, pos_q, pos_d;
    logic                      cured_q, cured_d, game_over_q, game_over_d;
    logic [POP_W-1:0]          col_v, act_v;
    logic [6:0]                cnt;
    logic [7:0]                n_live;
    logic [7:0]                health [N_TANK];
    logic [3:0]                lives [N_TANK];
    tank_state_e               state [N_TANK];
    logic [N_TANK-1:0]         alive_nxt, cure_ok;
`ifdef TANK_SCORE_EN
    logic [N_TANK-1:0]         hit_applied, kill;
    logic [N_TANK-1:0][15:0]   score_q, score_d;
    logic [15:0]               add;
    logic [16:0]               sum;
    logic                      contrib;
`endif

    for (genvar k = 0; k < N_TANK; k++) begin : g_tank
        tank_life_fsm #(
            .HW(HW), .INIT_HEALTH(INIT_HEALTH), .MAX_HEALTH(MAX_HEALTH),
            .INVULN_FRAMES(INVULN_FRAMES), .RESPAWN_FRAMES(RESPAWN_FRAMES), .LIVES(LIVES)
        ) u_fsm (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .hits      (hits[k]),
            .cure_req  (bus.to_cure[k]),
            .health    (health[k]),
            .lives     (lives[k]),
            .state     (state[k]),
            .alive_nxt (alive_nxt[k]),
`ifdef TANK_SCORE_EN
            .hit_applied (hit_applied[k]),
            .kill        (kill[k]),
`endif
            .cure_ok   (cure_ok[k])
        );
    end

    always_comb begin
        hits   = '0;
        bnum_d = '0;
        pos_d  = '0;
        col_v  = '0;
        act_v  = '0;
        cnt    = '0;
        n_live = '0;
        for (int k = 0; k < N_TANK; k++) begin
            col_v = '0;
            for (int i = 0; i < N_TANK * N_BULLET; i++) col_v[i] = bus.hit[i][k];
            cnt     = popcount(col_v);
            hits[k] = cnt[HW-1:0];
            act_v   = '0;
            act_v[N_BULLET-1:0] = bus.bullet_active[k];
            cnt       = popcount(act_v);
            bnum_d[k] = 32'(N_BULLET) - {25'b0, cnt};
            // alive bit follows the state the tank enters this frame, matching the FSM registers
            pos_d[k][POS_Y_LSB +: 10]  = bus.tank_y[k];
            pos_d[k][POS_X_LSB +: 10]  = bus.tank_x[k];
            pos_d[k][POS_ALIVE_BIT]    = alive_nxt[k];
            if (state[k] != ST_OUT) n_live = n_live + 8'd1;
        end
        cured_d     = (|cure_ok) & ~cured_q;
        game_over_d = game_over_q | (n_live <= 8'd1);
    end

`ifdef TANK_SCORE_EN
    // each hitting bullet earns its owner +1; owners that took part in a kill get +4 once
    always_comb begin
        score_d = score_q;
        add     = '0;
        sum     = '0;
        contrib = 1'b0;
        for (int s = 0; s < N_TANK; s++) begin
            add = '0;
            for (int j = 0; j < N_TANK; j++) begin
                contrib = 1'b0;
                if (j != s && hit_applied[j]) begin
                    for (int b = 0; b < N_BULLET; b++) begin
                        if (bus.hit[s*N_BULLET + b][j]) begin
                            add     = add + 16'd1;
                            contrib = 1'b1;
                        end
                    end
                    if (contrib && kill[j]) add = add + 16'd4;
                end
            end
            sum        = {1'b0, score_q[s]} + {1'b0, add};
            score_d[s] = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end
`endif

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int k = 0; k < N_TANK; k++) bnum_q[k] <= 32'(N_BULLET);
            pos_q       <= '0;
            cured_q     <= 1'b0;
            game_over_q <= 1'b0;
`ifdef TANK_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            bnum_q      <= bnum_d;
            pos_q       <= pos_d;
            cured_q     <= cured_d;
            game_over_q <= game_over_d;
`ifdef TANK_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    always_comb begin
        bus.health_attr_reg_out = '0;
        bus.tank_alive          = '0;
`ifdef TANK_SCORE_EN
        bus.score_reg           = '0;
`endif
        for (int k = 0; k < N_TANK; k++) begin
            bus.health_attr_reg_out[k][ATTR_HEALTH_LSB +: 8] = health[k];
            bus.health_attr_reg_out[k][ATTR_LIVES_LSB +: 4]  = lives[k];
            bus.health_attr_reg_out[k][ATTR_STATE_LSB +: 2]  = state[k];
            bus.tank_alive[k] = (state[k] == ST_ALIVE);
`ifdef TANK_SCORE_EN
            bus.score_reg[k] = {16'b0, score_q[k]};
`endif
        end
    end

    assign bus.bullet_num_reg = bnum_q;
    assign bus.tank_pos_reg   = pos_q;
    assign bus.cured          = cured_q;
    assign bus.game_over      = game_over_q;
endmodule
